// File: rtl/round_robin_dispatcher_with_2_outputs.sv
// rtl/round_robin_dispatcher_with_2_outputs.sv - splits one valid/ready stream across two outputs in round-robin order
// Each output owns a one-entry holding slot; a blocked favoured slot is skipped without a bubble.
module round_robin_dispatcher_with_2_outputs #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   output logic [1:0]       down_valid,
   input  logic [1:0]       down_ready,
   output logic [WIDTH-1:0] down_data_0,
   output logic [WIDTH-1:0] down_data_1
);

   logic [1:0]       valid_q, valid_d;
   logic [WIDTH-1:0] data0_q, data0_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic             next_q, next_d;
   logic [1:0]       free;
   logic             accept;
   logic             target;

   // A slot is usable this cycle if it is empty or its word leaves on this edge.
   assign free     = ~valid_q | down_ready;
   assign up_ready = free[0] | free[1];
   assign accept   = up_valid & up_ready;
   assign target   = free[next_q] ? next_q : ~next_q;

   always_comb begin
      valid_d = valid_q & ~down_ready;
      data0_d = data0_q;
      data1_d = data1_q;
      next_d  = next_q;
      if (accept) begin
         valid_d[target] = 1'b1;
         if (target == 1'b0) begin
            data0_d = up_data;
         end else begin
            data1_d = up_data;
         end
         next_d = ~target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 2'b00;
         data0_q <= '0;
         data1_q <= '0;
         next_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         next_q  <= next_d;
      end
   end

   assign down_valid  = valid_q;
   assign down_data_0 = data0_q;
   assign down_data_1 = data1_q;

endmodule

// File: doc/round_robin_dispatcher_with_2_outputs.md
# round_robin_dispatcher_with_2_outputs

Splits one valid/ready input stream across two output streams in round-robin order, which is the inverse of the two-request round-robin arbiter. It sits in front of two identical downstream workers and balances load between them. Each output has a one-entry holding register. When the favoured output cannot take a word, the word goes to the other output instead.

## Interface
- `WIDTH`, default 8: data width of the input stream and of each output stream.

- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `up_valid`  input  1  input word present.
- `up_ready`  output  1  dispatcher accepts the input word this cycle.
- `up_data`  input  WIDTH  input word.
- `down_valid`  output  2  bit i: output i holds a word.
- `down_ready`  input  2  bit i: consumer i takes the word this cycle.
- `down_data_0`  output  WIDTH  word held for output 0.
- `down_data_1`  output  WIDTH  word held for output 1.

## Operation
- **State**
  - `valid_q[1:0]` and `data_q0`, `data_q1`: one holding slot per output.
  - `next`: 1-bit pointer naming the favoured output.
- **Outputs**
  - `down_valid = valid_q`.
  - `down_data_i = data_q_i`.
  - Both are registered, with no combinational path from `up_*`.
- **Slot free**
  - `free[i] = !valid_q[i] | down_ready[i]`.
  - A slot is free if it is empty, or if its word drains in this same cycle.
- **Ready**
  - `up_ready = free[0] | free[1]`.
  - Combinational from `down_ready` and state only; it never depends on `up_valid`.
- **Accept** (`up_valid & up_ready`)
  - Target selection: `target = next` if `free[next]`, else `target = !next`.
  - Slot `target` loads `up_data` and its `valid_q[target]` is set.
  - `next <= !target`, so the pointer always moves to the output that did not just receive a word.
- **No accept**
  - `next` holds.
  - This includes `up_valid=0` and the case where both slots are full and not draining (`up_ready=0`).
- **Drain**
  - When `valid_q[i] & down_ready[i]` and slot i is not reloaded in the same cycle, `valid_q[i]` clears.
  - Simultaneous drain and reload of the same slot keeps `valid_q[i]=1` with the new data.
- **Holding rule**
  - A held word and its `down_valid` stay stable until taken; data never changes while `valid_q[i] & !down_ready[i]`.
- **Ordering**
  - No ordering guarantee across the two outputs.
  - Within one output, words appear in acceptance order.
- **Reset values**
  - `valid_q = 2'b00`, so `down_valid = 2'b00`.
  - `next = 0`.
  - `data_q0 = data_q1 = 0`.
  - `up_ready = 1` in the first cycle after reset.
- **Reset mid-operation**
  - Held words are discarded with no drain.
  - `rst` has priority over accept and drain in the same cycle.

## Timing
- **Latency:** a word accepted on edge N appears on `down_valid`/`down_data_i` from edge N onward, i.e. one cycle after it was presented.
- **Throughput:** one word per cycle while at least one slot is free or draining.
  - When both consumers are always ready, outputs alternate 0,1,0,1,...
- **Stall:** `up_ready=0` only when both slots are full and neither `down_ready` bit is set.
- **Skip:** if the favoured slot is blocked, the word goes to the other slot with no bubble. The pointer then returns to the blocked output, so it is favoured for the next word.

## Test plan
- **Reset and first word.** Assert `rst`, release it, then apply `up_valid=1`, `up_data=8'hA1`, `down_ready=2'b11` for one cycle.
  - During reset: `down_valid=00` and `up_ready=1`.
  - Next cycle: `down_valid=01` and `down_data_0=A1`.
- **Alternation.** Stream `11,22,33,44` back-to-back with `down_ready=11`.
  - Output 0 receives 11 then 33; output 1 receives 22 then 44.
  - `up_ready` stays 1 throughout.
- **Skip.** Fill output 0 and hold `down_ready[0]=0`, with `down_ready[1]=1`. Then send 55 and 66.
  - Both words go to output 1.
  - `next` returns to 0 after each word.
  - Output 0 keeps its original data stable.
- **Full stall.** Fill both slots, set `down_ready=00`, present `up_valid=1` for 3 cycles.
  - `up_ready=0` for all 3 cycles.
  - Slots unchanged.
  - Raising `down_ready[1]` gives `up_ready=1` in the same cycle, and the new word loads slot 1.
- **Same-cycle drain and reload.** With slot 0 full, `next=0` and `down_ready=01`, send 77.
  - `down_valid[0]` stays 1 with `down_data_0=77` and no bubble.
- **Reset mid-stream.** Assert `rst` while both slots are full.
  - Next cycle: `down_valid=00`.
  - The first word after release goes to output 0.
